// File: rtl/vertexinput_axil_frontend.sv
// AXI-Lite slave front end for the vertex-input register slices: decodes one
// transaction at a time into one-hot write/read pulses and returns the response.
module vertexinput_axil_frontend #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    output logic [1:0]                     s_bresp,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic [NUM_REGS-1:0]            mem_w_req,
    output logic [DATA_WIDTH-1:0]          mem_w_data,
    output logic [NUM_REGS-1:0]            mem_r_req,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] mem_r_data_local
);

    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_CAPT, RD_RESP
    } state_t;

    state_t                r_state;
    logic                  r_aw_vld;
    logic                  r_w_vld;
    logic                  r_rr_rd;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [STRB_W-1:0]     r_wstrb;

    logic                  w_idle;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_wr_rdy;
    logic                  w_wr_ok;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [STRB_W-1:0]     w_wr_strb;
    logic [DATA_WIDTH-1:0] w_rd_slice;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a[ADDR_WIDTH-1:2] < IDX_W'(NUM_REGS));
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
        return addr_ok(a) ? (NUM_REGS'(1) << a[ADDR_WIDTH-1:2]) : '0;
    endfunction

    // AR is held off when a complete write arrives this cycle and the write holds priority
    assign w_idle    = (r_state == IDLE);
    assign s_awready = w_idle && !r_aw_vld;
    assign s_wready  = w_idle && !r_w_vld;
    assign s_arready = w_idle && !r_aw_vld && !r_w_vld && !(s_awvalid && s_wvalid && !r_rr_rd);

    assign w_aw_hs   = s_awvalid && s_awready;
    assign w_w_hs    = s_wvalid && s_wready;
    assign w_ar_hs   = s_arvalid && s_arready;
    assign w_wr_rdy  = (r_aw_vld || w_aw_hs) && (r_w_vld || w_w_hs);
    assign w_wr_addr = r_aw_vld ? r_awaddr : s_awaddr;
    assign w_wr_strb = r_w_vld ? r_wstrb : s_wstrb;
    assign w_wr_ok   = addr_ok(w_wr_addr) && (&w_wr_strb);

    // Slice mux for the latched read address
    always_comb begin
        w_rd_slice = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (r_araddr[ADDR_WIDTH-1:2] == IDX_W'(i))
                w_rd_slice = mem_r_data_local[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_aw_vld   <= 1'b0;
            r_w_vld    <= 1'b0;
            r_rr_rd    <= 1'b1;
            r_awaddr   <= '0;
            r_araddr   <= '0;
            r_wstrb    <= '0;
            s_bvalid   <= 1'b0;
            s_bresp    <= RESP_OKAY;
            s_rvalid   <= 1'b0;
            s_rresp    <= RESP_OKAY;
            s_rdata    <= '0;
            mem_w_req  <= '0;
            mem_w_data <= '0;
            mem_r_req  <= '0;
        end else begin
            mem_w_req <= '0;
            mem_r_req <= '0;
            case (r_state)
                IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_vld <= 1'b1;
                        r_awaddr <= s_awaddr;
                    end
                    if (w_w_hs) begin
                        r_w_vld    <= 1'b1;
                        mem_w_data <= s_wdata;
                        r_wstrb    <= s_wstrb;
                    end
                    if (w_ar_hs) begin
                        r_araddr  <= s_araddr;
                        mem_r_req <= onehot(s_araddr);
                        r_rr_rd   <= !r_rr_rd;
                        r_state   <= RD_ISSUE;
                    end else if (w_wr_rdy) begin
                        mem_w_req <= w_wr_ok ? onehot(w_wr_addr) : '0;
                        r_rr_rd   <= !r_rr_rd;
                        r_state   <= WR_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    s_bvalid <= 1'b1;
                    s_bresp  <= (addr_ok(r_awaddr) && (&r_wstrb)) ? RESP_OKAY : RESP_SLVERR;
                    r_state  <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        r_aw_vld <= 1'b0;
                        r_w_vld  <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                RD_ISSUE: r_state <= RD_CAPT;
                RD_CAPT: begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= addr_ok(r_araddr) ? w_rd_slice : '0;
                    s_rresp  <= addr_ok(r_araddr) ? RESP_OKAY : RESP_SLVERR;
                    r_state  <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
